// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl.
//   master : pipeline side. Drives the IF/ID and ID/EX fields and branch_taken.
//            Receives the stage-register controls, FSM state and counters.
//   slave  : hazard_ctrl side.
interface hazard_ctrl_if;
   logic [31:0] if_instr;
   logic [6:0]  ex_opcode;
   logic [6:0]  ex_funct7;
   logic [4:0]  ex_rd;
   logic        branch_taken;
   logic        pc_stall;
   logic        ifid_stall;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        ex_hold;
   logic [1:0]  state_o;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output if_instr, ex_opcode, ex_funct7, ex_rd, branch_taken,
      input  pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold,
      input  state_o, stall_cycles, flush_count
   );

   modport slave (
      input  if_instr, ex_opcode, ex_funct7, ex_rd, branch_taken,
      output pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold,
      output state_o, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core.
// It watches IF/ID (if_instr) and ID/EX (ex_*). It produces the stall, bubble,
// flush and hold controls for load-use hazards, taken branches and
// multi-cycle MUL occupancy of EX. It also keeps saturating stall and flush
// counters.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    hazard_ctrl_if.slave. Carries the pipeline inputs, the combinational
//          controls, state_o and the counters.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RUN       | normal flow; branch / new MUL / load-use handled
// MUL_BUSY  | MUL still occupying EX, pipeline frozen
// MUL_DRAIN | last MUL cycle; behaves like RUN without a new MUL trigger
module hazard_ctrl #(
   parameter int MUL_LATENCY = 3
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MUL_BUSY  = 2'd1,
      MUL_DRAIN = 2'd2
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam bit         MUL_STALLS   = (MUL_LATENCY > 1);
   localparam bit         MUL_NO_BUSY  = (MUL_LATENCY == 2);
   localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 2);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   logic rs1_used, rs2_used;
   logic load_use, is_mul, mul_start;
   logic pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold;

   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (bus.if_instr[6:0])
         OPC_IMM, OPC_LOAD:              rs1_used = 1'b1;
         OPC_STORE, OPC_OP, OPC_BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         default: ;
      endcase
   end

   assign load_use = (bus.ex_opcode == OPC_LOAD) && (bus.ex_rd != 5'd0) &&
                     ((rs1_used && (bus.if_instr[19:15] == bus.ex_rd)) ||
                      (rs2_used && (bus.if_instr[24:20] == bus.ex_rd)));

   assign is_mul = (bus.ex_opcode == OPC_OP) && (bus.ex_funct7 == F7_MULDIV);

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      ex_hold     = 1'b0;
      mul_start   = 1'b0;
      if (!reset) begin
         if (state_q == MUL_BUSY) begin
            ex_hold    = 1'b1;
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
         end else if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if ((state_q == RUN) && is_mul && MUL_STALLS) begin
            ex_hold    = 1'b1;
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            mul_start  = 1'b1;
         end else if (load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
         end
      end
   end

   // cnt_q counts the MUL_BUSY cycles still to come, including the current
   // one. MUL_BUSY therefore lasts MUL_LATENCY-2 cycles, and the total hold is
   // MUL_LATENCY-1 cycles. A latency of 2 skips MUL_BUSY and goes straight to
   // the drain cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         cnt_q       <= 4'd0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            RUN: begin
               if (mul_start) begin
                  cnt_q   <= MUL_CNT_INIT;
                  state_q <= MUL_NO_BUSY ? MUL_DRAIN : MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd1) state_q <= MUL_DRAIN;
            end
            MUL_DRAIN: state_q <= RUN;
            default:   state_q <= RUN;
         endcase

         if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ifid_flush && (flush_cnt_q != 16'hFFFF))
            flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign bus.pc_stall     = pc_stall;
   assign bus.ifid_stall   = ifid_stall;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_bubble  = idex_bubble;
   assign bus.ex_hold      = ex_hold;
   assign bus.state_o      = state_q;
   assign bus.stall_cycles = stall_cnt_q;
   assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
   localparam int L = 3;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] F7_MUL   = 7'b0000001;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] ADD_657  = {7'b0, 5'd7, 5'd5, 3'b000, 5'd6, OP_OP};
   localparam logic [31:0] JAL_X5   = {7'b0, 5'd5, 5'd5, 3'b000, 5'd5, OP_JAL};
   localparam logic [31:0] AUIPC_X5 = {7'b0, 5'd5, 5'd5, 3'b000, 5'd5, OP_AUIPC};
   localparam logic [31:0] SW_X5    = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, OP_STORE};

   // control vector order: pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold
   localparam logic [4:0] C_NONE = 5'b00000;
   localparam logic [4:0] C_LU   = 5'b11010;
   localparam logic [4:0] C_MUL  = 5'b11001;
   localparam logic [4:0] C_BR   = 5'b00110;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_ctrl_if bus();
   hazard_ctrl_if bus1();

   hazard_ctrl #(.MUL_LATENCY(L)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
   hazard_ctrl #(.MUL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   assign bus1.if_instr     = bus.if_instr;
   assign bus1.ex_opcode    = bus.ex_opcode;
   assign bus1.ex_funct7    = bus.ex_funct7;
   assign bus1.ex_rd        = bus.ex_rd;
   assign bus1.branch_taken = bus.branch_taken;

   int total = 0;
   int bad   = 0;

   function automatic logic [4:0] ctl();
      return {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble, bus.ex_hold};
   endfunction

   function automatic logic [4:0] ctl1();
      return {bus1.pc_stall, bus1.ifid_stall, bus1.ifid_flush, bus1.idex_bubble, bus1.ex_hold};
   endfunction

   // Sets the inputs just after a falling edge; outputs settle before the next rising edge.
   task automatic drive(input logic [31:0] ins, input logic [6:0] op, input logic [6:0] f7,
                        input logic [4:0] rd, input logic br);
      @(negedge clk);
      bus.if_instr     = ins;
      bus.ex_opcode    = op;
      bus.ex_funct7    = f7;
      bus.ex_rd        = rd;
      bus.branch_taken = br;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.if_instr = NOP; bus.ex_opcode = 7'd0; bus.ex_funct7 = 7'd0;
      bus.ex_rd = 5'd0; bus.branch_taken = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference rule: a source register of the IF/ID instruction matches a load in EX.
   function automatic logic model_lu(logic [31:0] ins, logic [6:0] op, logic [4:0] rd);
      logic u1, u2;
      u1 = ins[6:0] inside {OP_IMM, OP_LOAD, OP_STORE, OP_OP, OP_BR};
      u2 = ins[6:0] inside {OP_STORE, OP_OP, OP_BR};
      return (op == OP_LOAD) && (rd != 0) &&
             ((u1 && ins[19:15] == rd) || (u2 && ins[24:20] == rd));
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b1);
      total++;
      if (ctl() !== C_NONE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), C_NONE); end
      total++;
      if (bus.state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
      @(negedge clk); #1;
      total++;
      if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 16'd0) begin
         bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_count);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (ctl() !== C_LU) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl(), C_LU); end
      drive(ADD_657, 7'd0, 7'd0, 5'd0, 1'b0);
      total++;
      if (ctl() !== C_NONE) begin bad++; $display("FAIL lu_after_bubble got=%b exp=%b", ctl(), C_NONE); end
      total++;
      if (bus.stall_cycles !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", bus.stall_cycles); end
      drive({7'b0, 5'd0, 5'd0, 3'b000, 5'd6, OP_OP}, OP_LOAD, 7'd0, 5'd0, 1'b0);
      total++;
      if (ctl() !== C_NONE) begin bad++; $display("FAIL lu_rd0 got=%b exp=%b", ctl(), C_NONE); end
   endtask

   task automatic test_non_user();
      do_reset();
      drive(JAL_X5, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (ctl() !== C_NONE) begin bad++; $display("FAIL nonuser_jal got=%b exp=%b", ctl(), C_NONE); end
      drive(AUIPC_X5, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (ctl() !== C_NONE) begin bad++; $display("FAIL nonuser_auipc got=%b exp=%b", ctl(), C_NONE); end
      drive(SW_X5, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (ctl() !== C_LU) begin bad++; $display("FAIL store_rs2 got=%b exp=%b", ctl(), C_LU); end
      drive(NOP, 7'd0, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.stall_cycles !== 32'd1) begin bad++; $display("FAIL nonuser_cnt got=%0d exp=1", bus.stall_cycles); end
   endtask

   task automatic test_mul();
      logic [1:0] es [3] = '{2'd0, 2'd1, 2'd2};
      logic [4:0] ec [3] = '{C_MUL, C_MUL, C_NONE};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(NOP, OP_OP, F7_MUL, 5'd3, 1'b0);
         total++;
         if (bus.state_o !== es[i] || ctl() !== ec[i]) begin
            bad++; $display("FAIL mul_seq[%0d] got=%0d/%b exp=%0d/%b", i, bus.state_o, ctl(), es[i], ec[i]);
         end
         total++;
         if (bus1.state_o !== 2'd0 || ctl1() !== C_NONE) begin
            bad++; $display("FAIL mul_lat1[%0d] got=%0d/%b exp=0/%b", i, bus1.state_o, ctl1(), C_NONE);
         end
      end
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.state_o !== 2'd0 || bus.stall_cycles !== 32'd2) begin
         bad++; $display("FAIL mul_end got=%0d/%0d exp=0/2", bus.state_o, bus.stall_cycles);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] es [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(NOP, OP_OP, F7_MUL, 5'd4, 1'b0);
         total++;
         if (bus.state_o !== es[i] || bus.ex_hold !== (es[i] != 2'd2)) begin
            bad++; $display("FAIL b2b_seq[%0d] got=%0d/%b exp=%0d/%b", i, bus.state_o, bus.ex_hold, es[i], es[i] != 2'd2);
         end
      end
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.state_o !== 2'd0 || bus.stall_cycles !== 32'd4) begin
         bad++; $display("FAIL b2b_end got=%0d/%0d exp=0/4", bus.state_o, bus.stall_cycles);
      end
   endtask

   task automatic test_branch_load_use();
      do_reset();
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b1);
      total++;
      if (ctl() !== C_BR) begin bad++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl(), C_BR); end
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b1);
      total++;
      if (bus.flush_count !== 16'd1 || bus.stall_cycles !== 32'd0) begin
         bad++; $display("FAIL br_lu_cnt got=%0d/%0d exp=1/0", bus.flush_count, bus.stall_cycles);
      end
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.flush_count !== 16'd2 || ctl() !== C_NONE) begin
         bad++; $display("FAIL br_consec got=%0d/%b exp=2/%b", bus.flush_count, ctl(), C_NONE);
      end
   endtask

   task automatic test_reset_mid_mul();
      do_reset();
      drive(NOP, OP_OP, F7_MUL, 5'd3, 1'b0);
      drive(NOP, OP_OP, F7_MUL, 5'd3, 1'b0);
      total++;
      if (bus.state_o !== 2'd1) begin bad++; $display("FAIL rstmul_busy got=%0d exp=1", bus.state_o); end
      reset = 1'b1;
      #1;
      total++;
      if (ctl() !== C_NONE || bus.state_o !== 2'd0 || bus.stall_cycles !== 32'd0) begin
         bad++; $display("FAIL rstmul_abort got=%b/%0d/%0d exp=%b/0/0", ctl(), bus.state_o, bus.stall_cycles, C_NONE);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.ex_opcode = OP_IMM; bus.ex_funct7 = 7'd0; bus.ex_rd = 5'd0;
      #1;
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.ex_hold !== 1'b0 || bus.state_o !== 2'd0) begin
         bad++; $display("FAIL rstmul_after got=%b/%0d exp=0/0", bus.ex_hold, bus.state_o);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      @(negedge clk);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (bus.stall_cycles !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffffffe", bus.stall_cycles); end
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b0);
      total++;
      if (bus.stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_step got=%h exp=ffffffff", bus.stall_cycles); end
      drive(ADD_657, OP_LOAD, 7'd0, 5'd5, 1'b0);
      drive(NOP, OP_IMM, 7'd0, 5'd0, 1'b0);
      total++;
      if (bus.stall_cycles !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffffffff", bus.stall_cycles); end
   endtask

   task automatic test_random();
      logic [6:0] opcs [8] = '{OP_IMM, OP_LOAD, OP_STORE, OP_OP, OP_BR, OP_JAL, OP_AUIPC, OP_LUI};
      int age = -1;        // cycles since the current MUL entered EX, -1 if none
      int ea;
      longint e_stall = 0;
      longint e_flush = 0;
      logic [31:0] ins;
      logic [6:0] op = 7'd0, f7 = 7'd0;
      logic [4:0] rd = 5'd0;
      logic br, mul;
      logic [4:0] ec;
      logic [1:0] es;
      int r;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         ins = {7'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom), opcs[$urandom_range(0, 7)]};
         if (age >= 0) begin
            br = 1'b0;
         end else begin
            r  = $urandom_range(0, 9);
            rd = 5'($urandom_range(0, 7));
            f7 = 7'd0;
            if (r < 3)      op = OP_LOAD;
            else if (r < 5) begin op = OP_OP; f7 = F7_MUL; end
            else if (r < 6) op = OP_OP;
            else            op = opcs[$urandom_range(0, 7)];
            mul = (op == OP_OP) && (f7 == F7_MUL);
            br  = !mul && ($urandom_range(0, 5) == 0);
         end
         mul = (op == OP_OP) && (f7 == F7_MUL);
         ea = age;
         if (age < 0 && mul && L > 1) ea = 0;
         if (ea >= 0 && ea <= L - 2)      ec = C_MUL;
         else if (br)                     ec = C_BR;
         else if (model_lu(ins, op, rd))  ec = C_LU;
         else                             ec = C_NONE;
         es = (ea <= 0) ? 2'd0 : ((ea == L - 1) ? 2'd2 : 2'd1);

         drive(ins, op, f7, rd, br);
         total++;
         if (ctl() !== ec) begin bad++; $display("FAIL rnd_ctl[%0d] got=%b exp=%b", n, ctl(), ec); end
         total++;
         if (bus.state_o !== es) begin bad++; $display("FAIL rnd_state[%0d] got=%0d exp=%0d", n, bus.state_o, es); end
         total++;
         if (bus.stall_cycles !== 32'(e_stall) || bus.flush_count !== 16'(e_flush)) begin
            bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, bus.stall_cycles, bus.flush_count, e_stall, e_flush);
         end

         if (ec[4] && e_stall < 64'hFFFF_FFFF) e_stall++;
         if (ec[2] && e_flush < 64'hFFFF)      e_flush++;
         if (ea >= 0) begin
            age = ea + 1;
            if (age > L - 1) age = -1;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.if_instr = NOP; bus.ex_opcode = 7'd0; bus.ex_funct7 = 7'd0;
      bus.ex_rd = 5'd0; bus.branch_taken = 1'b0;
      test_reset();
      test_load_use();
      test_non_user();
      test_mul();
      test_back_to_back();
      test_branch_load_use();
      test_reset_mid_mul();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
